// File: rtl/core_pkg.sv
// Shared core definitions: stage sequencer encodings and architectural widths.
package core_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } stage_e;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

endpackage

// File: rtl/reg_file.sv
// Integer register file: two asynchronous read ports, one synchronous write port, x0 reads as zero.
module reg_file
    import core_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [XLEN-1:0]       rdata1,
    output logic [XLEN-1:0]       rdata2
);

    logic [XLEN-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0) && (int'(waddr) < NUM_REGS)) begin
            regs[waddr] <= wdata;
        end
    end

    // No write-to-read bypass: a read in the write cycle sees the old contents.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if ((raddr1 != '0) && (int'(raddr1) < NUM_REGS)) rdata1 = regs[raddr1];
        if ((raddr2 != '0) && (int'(raddr2) < NUM_REGS)) rdata2 = regs[raddr2];
    end

endmodule

// File: rtl/write_back.sv
// Write-back stage: owns the stage sequencer, PC and register file; commits on leaving WB.
// Optional WB_INSTRET_EN adds a 64-bit retired-instruction counter output.
module write_back
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  branch_in,
    input  logic                  reg_write_in,
    input  logic [REG_ADDR_W-1:0] write_reg_in,
    input  logic [XLEN-1:0]       branch_addr_in,
    input  logic [XLEN-1:0]       reg_write_data_in,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    output logic [2:0]            state,
    output logic [XLEN-1:0]       pc,
`ifdef WB_INSTRET_EN
    output logic [63:0]           instret,
`endif
    output logic                  retire
);

    logic [2:0] state_n;
    logic       commit;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IF;
        else     state <= state_n;
    end

    // Unreachable encodings recover to fetch even under stall, without committing.
    always_comb begin
        state_n = state;
        commit  = 1'b0;
        case (state)
            S_IF:  if (!stall) state_n = S_ID;
            S_ID:  if (!stall) state_n = S_EX;
            S_EX:  if (!stall) state_n = S_MEM;
            S_MEM: if (!stall) state_n = S_WB;
            S_WB: begin
                if (!stall) begin
                    state_n = S_IF;
                    commit  = 1'b1;
                end
            end
            default: state_n = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            retire <= 1'b0;
        end else begin
            retire <= commit;
            if (commit) pc <= branch_in ? branch_addr_in : pc + PC_STEP;
        end
    end

`ifdef WB_INSTRET_EN
    always_ff @(posedge clk) begin
        if (rst)         instret <= '0;
        else if (commit) instret <= instret + 64'd1;
    end
`endif

    reg_file #(
        .NUM_REGS(NUM_REGS)
    ) u_reg_file (
        .clk    (clk),
        .rst    (rst),
        .we     (commit & reg_write_in),
        .waddr  (write_reg_in),
        .wdata  (reg_write_data_in),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

endmodule

// File: tb/tb_write_back.sv
// Self-checking bench for write_back: per-cycle model comparison plus literal expectations.
module tb_write_back;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_in;
    logic        reg_write_in;
    logic [4:0]  write_reg_in;
    logic [31:0] branch_addr_in;
    logic [31:0] reg_write_data_in;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [2:0]  state;
    logic [31:0] pc;
    logic        retire;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    write_back #(
        .RESET_PC(32'h0000_0000),
        .NUM_REGS(32)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .branch_in         (branch_in),
        .reg_write_in      (reg_write_in),
        .write_reg_in      (write_reg_in),
        .branch_addr_in    (branch_addr_in),
        .reg_write_data_in (reg_write_data_in),
        .rs1_addr          (rs1_addr),
        .rs2_addr          (rs2_addr),
        .rs1_data          (rs1_data),
        .rs2_data          (rs2_data),
        .state             (state),
        .pc                (pc),
`ifdef WB_INSTRET_EN
        .instret           (instret),
`endif
        .retire            (retire)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural model: instruction phase counter, register array, PC.
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_regs [32];
    logic        m_retire;
    logic [63:0] m_instret;
    bit          m_valid = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase   = 0;
            m_pc      = 32'h0;
            m_retire  = 0;
            m_instret = 0;
            foreach (m_regs[i]) m_regs[i] = 32'h0;
            m_valid   = 1;
        end else if (m_valid) begin
            m_retire = 0;
            if (!stall) begin
                if (m_phase == 4) begin
                    if (reg_write_in && write_reg_in != 0) m_regs[write_reg_in] = reg_write_data_in;
                    m_pc      = branch_in ? branch_addr_in : m_pc + 32'd4;
                    m_retire  = 1;
                    m_instret = m_instret + 1;
                end
                m_phase = (m_phase + 1) % 5;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("state", {61'd0, state}, 64'(m_phase));
            chk("pc", {32'd0, pc}, {32'd0, m_pc});
            chk("retire", {63'd0, retire}, {63'd0, m_retire});
            chk("rs1_data", {32'd0, rs1_data}, {32'd0, m_regs[rs1_addr]});
            chk("rs2_data", {32'd0, rs2_data}, {32'd0, m_regs[rs2_addr]});
`ifdef WB_INSTRET_EN
            chk("instret", instret, m_instret);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic to_wb();
        int n = 0;
        while (state != 3'd4 && n < 12) begin
            step();
            n++;
        end
        chk("reach_wb", {61'd0, state}, 64'd4);
    endtask

    task automatic set_in(input logic br, input logic [31:0] ba, input logic we,
                          input logic [4:0] wr, input logic [31:0] wd);
        branch_in         = br;
        branch_addr_in    = ba;
        reg_write_in      = we;
        write_reg_in      = wr;
        reg_write_data_in = wd;
    endtask

    task automatic commit(input logic br, input logic [31:0] ba, input logic we,
                          input logic [4:0] wr, input logic [31:0] wd);
        set_in(br, ba, we, wr, wd);
        to_wb();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] seq [6];
        seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        rst = 1'b1;
        stall = 1'b0;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        set_in(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        step();
        rst = 1'b0;
        chk("reset_state", {61'd0, state}, 64'd0);
        chk("reset_pc", {32'd0, pc}, 64'd0);
        chk("reset_retire", {63'd0, retire}, 64'd0);

        // Basic write of x5, no branch
        set_in(1'b0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF);
        rs1_addr = 5'd5;
        rs2_addr = 5'd5;
        for (int i = 0; i < 6; i++) begin
            chk("seq_state", {61'd0, state}, {61'd0, seq[i]});
            if (i < 5) step();
        end
        chk("x5_written", {32'd0, rs1_data}, 64'hDEADBEEF);
        chk("pc_after_first", {32'd0, pc}, 64'h4);
        chk("retire_pulse", {63'd0, retire}, 64'd1);
        step();
        chk("retire_clears", {63'd0, retire}, 64'd0);
`ifdef WB_INSTRET_EN
        chk("instret_one", instret, 64'd1);
`endif

        // Branch then sequential
        commit(1'b1, 32'h100, 1'b0, 5'd3, 32'h0);
        chk("branch_pc", {32'd0, pc}, 64'h100);
        commit(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("seq_pc", {32'd0, pc}, 64'h104);

        // Write to x0 is dropped
        rs1_addr = 5'd0;
        commit(1'b0, 32'h0, 1'b1, 5'd0, 32'h1234);
        chk("x0_read", {32'd0, rs1_data}, 64'h0);
        chk("x0_retire", {63'd0, retire}, 64'd1);
        chk("x0_pc", {32'd0, pc}, 64'h108);

        // Stall in WB for three cycles
        rs1_addr = 5'd9;
        set_in(1'b0, 32'h0, 1'b1, 5'd9, 32'h99);
        to_wb();
        stall = 1'b1;
        repeat (3) step();
        chk("stall_state", {61'd0, state}, 64'd4);
        chk("stall_pc", {32'd0, pc}, 64'h108);
        chk("stall_nowrite", {32'd0, rs1_data}, 64'h0);
        stall = 1'b0;
        step();
        chk("unstall_state", {61'd0, state}, 64'd0);
        chk("unstall_pc", {32'd0, pc}, 64'h10C);
        chk("unstall_write", {32'd0, rs1_data}, 64'h99);
        chk("unstall_retire", {63'd0, retire}, 64'd1);

        // Commit-cycle read hazard on x7
        rs1_addr = 5'd7;
        set_in(1'b0, 32'h0, 1'b1, 5'd7, 32'hA5);
        to_wb();
        chk("hazard_old", {32'd0, rs1_data}, 64'h0);
        step();
        chk("hazard_new", {32'd0, rs1_data}, 64'hA5);

        // PC wrap
        commit(1'b1, 32'hFFFF_FFFC, 1'b0, 5'd0, 32'h0);
        chk("wrap_pre", {32'd0, pc}, 64'hFFFF_FFFC);
        commit(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("wrap_pc", {32'd0, pc}, 64'h0);

        // Reset in WB with a pending write
        rs1_addr = 5'd12;
        rs2_addr = 5'd5;
        set_in(1'b1, 32'h200, 1'b1, 5'd12, 32'h5555);
        to_wb();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstwb_state", {61'd0, state}, 64'd0);
        chk("rstwb_pc", {32'd0, pc}, 64'h0);
        chk("rstwb_x12", {32'd0, rs1_data}, 64'h0);
        chk("rstwb_x5", {32'd0, rs2_data}, 64'h0);
        chk("rstwb_retire", {63'd0, retire}, 64'd0);
`ifdef WB_INSTRET_EN
        chk("rstwb_instret", instret, 64'd0);
`endif
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/write_back.md
Name: write_back

Overview:
- Final stage of the multi-cycle core. It consumes the registered outputs of the memory stage and owns the architectural state.
- Owns the 5-state stage sequencer that every stage decodes, the 32x32 integer register file, and the PC.
- In the WB state it commits the register write and the next PC, then returns the sequencer to fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NUM_REGS, 32, register file depth; x0 is hardwired to zero.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- stall  in  1  holds the sequencer in its current state while high.
- branch_in  in  1  memory-stage branch-taken flag.
- reg_write_in  in  1  memory-stage register write enable.
- write_reg_in  in  5  destination register index.
- branch_addr_in  in  32  branch target.
- reg_write_data_in  in  32  write-back value.
- rs1_addr  in  5  read port 1 index.
- rs2_addr  in  5  read port 2 index.
- rs1_data  out  32  read port 1 data, combinational.
- rs2_data  out  32  read port 2 data, combinational.
- state  out  3  current stage: 0 IF, 1 ID, 2 EX, 3 MEM, 4 WB.
- pc  out  32  current instruction address.
- retire  out  1  one-cycle pulse when an instruction commits.

Behaviour:
- Reset (rst high at a posedge):
  - state=0, pc=RESET_PC, retire=0.
  - All registers cleared to 0.
  - rst has priority over stall and over a WB commit in the same cycle.
- Sequencer:
  - Each posedge with stall=0: state advances 0->1->2->3->4->0.
  - With stall=1: state holds and nothing commits.
  - Values 5..7 are unreachable; if ever present, next state=0 and nothing commits.
- Commit, on the posedge leaving state 4 with stall=0:
  - If reg_write_in=1 and write_reg_in!=0: regs[write_reg_in] <= reg_write_data_in.
  - pc <= branch_in ? branch_addr_in : pc+4. Addition wraps mod 2^32, so 32'hFFFF_FFFC+4 = 0.
  - retire=1 for exactly the following cycle (while state=0); otherwise 0.
- Write to x0 is discarded silently. x0 reads always return 0.
- Reads:
  - Asynchronous.
  - A read of the register being written in the commit cycle returns the old value. The new value is visible from the next cycle; there is no internal bypass.
- Inputs are sampled only in state 4. Values in other states are ignored.
- pc is stable through states 0-4 of one instruction.
- Stall in state 4 delays the commit. The inputs must stay valid while stall is high; the memory stage holds its outputs outside state 3, so this is met.
- Reset mid-instruction (any state) abandons the instruction with no partial commit.

Optional Feature:
- Macro WB_INSTRET_EN.
- Defined:
  - Adds output instret[63:0], reset to 0, incremented by 1 on each commit.
  - Wraps at 2^64-1 -> 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package core_pkg:
  - State encodings S_IF=0, S_ID=1, S_EX=2, S_MEM=3, S_WB=4.
  - XLEN=32, REG_ADDR_W=5, PC_STEP=4.
  - Shared by every stage so the state==3 style comparisons use the named constants.
- Sub-module reg_file:
  - 2 async read ports, 1 sync write port.
  - x0 masking and sync clear on reset.
- write_back instantiates reg_file and holds the sequencer, PC and retire logic.

Test Plan:
- Reset then 5 unstalled cycles with reg_write_in=1, write_reg_in=5, data=32'hDEADBEEF, branch_in=0:
  - state sequence 0,1,2,3,4,0.
  - After commit, regs[5]=DEADBEEF, pc=4, retire high one cycle.
- Branch commit with branch_in=1, branch_addr_in=32'h100 -> pc=32'h100. A following non-branch instruction -> pc=32'h104.
- Write to x0 with data 32'h1234 -> rs1_addr=0 reads 0. retire still pulses and pc still advances.
- stall=1 for 3 cycles in state 4:
  - state stays 4 and no write or pc change occurs.
  - Commit happens on the first posedge after stall drops.
- Commit-cycle hazard with rs1_addr=7 while writing 7 <- 32'hA5: rs1_data shows the old value in the commit cycle and 32'hA5 in the next.
- rst asserted in state 4 with a pending write -> register unchanged (0), pc=RESET_PC, state=0. With WB_INSTRET_EN defined, instret=0.
